cpu_run_monitor: RTL and testbench
==================================

Name: cpu_run_monitor

Overview:
- Synthesizable run-control and console-capture block for the cpu core, replacing hard-coded bench sequencing (fixed reset pulse, fixed cycle budget).
- Generates the core's reset for a programmable number of cycles, counts run cycles against a budget, and decodes the core's uart_tx line into bytes.
- Sits beside cpu at the board/bench top; usable on FPGA (bytes to a debug FIFO/LEDs) and in simulation (bench watches done).

Parameters:
- RESET_CYCLES, 16: cycles core_resetn is held low after run start.
- CNT_W, 32: width of cycle counter and budget.
- MAX_CYCLES, 3276800: run-cycle budget before timeout; must be ≥1 and < 2^CNT_W.
- CLKS_PER_BIT, 868: sysclk cycles per UART bit (100 MHz / 115200); must be ≥4.
- DATA_BITS, 8: UART data bits, 8N1 framing, LSB first.
- END_CHAR, 8'h04: terminating byte (used only with the optional feature).

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- cpu_reset  in  1  synchronous, active-high reset of this block.
- run_en  in  1  level; 1 starts a run from IDLE.
- core_resetn  out  1  active-low reset to the cpu core.
- uart_rx_in  in  1  connected to the cpu uart_tx; asynchronous, idle high.
- rx_data  out  DATA_BITS  last received byte; holds until the next valid byte.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- rx_frame_err  out  1  one-cycle pulse; stop bit sampled low.
- byte_count  out  16  valid bytes received this run; saturates at 16'hFFFF.
- cycle_count  out  CNT_W  cycles spent in RUN this run.
- timeout  out  1  sticky; the budget was exhausted.
- done  out  1  sticky; the run has ended.

Behaviour:
- Reset: cpu_reset is sampled synchronously on sysclk. While it is 1, all outputs go to 0: core_resetn=0, rx_data=0, counters=0, flags=0. The controller enters IDLE and the receiver enters RX_IDLE. This also applies mid-run or mid-byte, and any partial byte is dropped.
- Controller FSM:
  - IDLE: core_resetn=0. If run_en=1, go to HOLD_RST and clear cycle_count, byte_count, timeout and done.
  - HOLD_RST: core_resetn=0 for exactly RESET_CYCLES cycles, then go to RUN.
  - RUN: core_resetn=1 and cycle_count increments every cycle. When cycle_count==MAX_CYCLES-1 is incremented, the next cycle shows cycle_count=MAX_CYCLES, timeout=1, done=1, and the state is DONE.
  - DONE: core_resetn=0; cycle_count and byte_count frozen. If run_en=0, return to IDLE while keeping done, timeout and counts visible until the next run starts.
  - run_en deasserted during HOLD_RST or RUN: no effect. Runs end only by timeout, END_CHAR (optional feature) or cpu_reset.
- Receiver:
  - uart_rx_in passes through a 2-flop synchronizer, giving 2 cycles of latency. All samples below use the synchronized value.
  - RX_IDLE: a falling edge (previous 1, current 0) goes to RX_START.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 1, treat it as a glitch and return to RX_IDLE with no pulse. If 0, go to RX_DATA.
  - RX_DATA: take DATA_BITS samples, one every CLKS_PER_BIT cycles, shifting LSB first. Then go to RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - Sample 1: on the cycle after the stop sample, rx_data is updated, rx_valid=1, byte_count increments, then RX_IDLE.
    - Sample 0: rx_frame_err=1 and rx_data is unchanged. The receiver then waits for the line to read 1 before returning to RX_IDLE.
  - The receiver is active in all controller states, but byte_count only counts while in RUN.
- Simultaneous events: a timeout and a valid byte in the same cycle both take effect, so the byte is counted and timeout has priority for the flag. rx_valid and rx_frame_err are never asserted together.

Optional Feature:
- RUN_MON_END_CHAR_EN defined:
  - A valid byte equal to END_CHAR received in RUN ends the run: the next cycle shows done=1, timeout=0 and state DONE, and that byte is still counted.
  - If END_CHAR and timeout land in the same cycle, both done=1 and timeout=1.
- RUN_MON_END_CHAR_EN not defined: END_CHAR is ignored and only timeout ends a run. The END_CHAR parameter is unused.

Test Plan:
Common settings: CLKS_PER_BIT=16, RESET_CYCLES=4, MAX_CYCLES=1000.
- Reset/start: cpu_reset 1→0, run_en=1 → core_resetn low for 4 cycles after HOLD_RST entry, then high; cycle_count counts 1, 2, 3, ….
- Budget: line held idle → exactly 1000 RUN cycles, then timeout=1, done=1, core_resetn=0, cycle_count stays at 1000.
- Byte RX: drive 8'h41 in 8N1 → one rx_valid pulse with rx_data=8'h41 and byte_count=1. Two back-to-back bytes 8'h0A, 8'h55 → two pulses in order.
- Framing/glitch: stop bit forced 0 → rx_frame_err pulse, rx_data unchanged, byte_count unchanged. 4-cycle low glitch → no pulse.
- Mid-operation reset: assert cpu_reset during bit 3 of a byte → all outputs 0, no rx_valid. The next full byte is received correctly.
- With RUN_MON_END_CHAR_EN: send 8'h04 at cycle ~300 → done=1, timeout=0, byte_count=1. Without the macro, the same stimulus ends only at cycle 1000 with timeout=1.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run control and console capture for the cpu core.
//
// Holds the core in reset for RESET_CYCLES after a run is requested, then
// releases it and counts run cycles against MAX_CYCLES. In parallel it
// decodes the core's uart_tx line (8N1, LSB first) into bytes.
//
// Optional feature: define RUN_MON_END_CHAR_EN so that a received END_CHAR
// byte while running ends the run early. Without the macro only the cycle
// budget (or cpu_reset) ends a run.
//
// Ports:
//   sysclk          in   system clock, rising edge
//   cpu_reset       in   synchronous active-high reset of this block
//   run_en          in   level; starts a run from IDLE
//   core_resetn     out  active-low reset to the cpu core
//   uart_rx_in      in   core uart_tx, asynchronous, idle high
//   rx_data         out  last good byte, held until the next good byte
//   rx_valid        out  one-cycle strobe, rx_data is new
//   rx_frame_err    out  one-cycle strobe, stop bit sampled low
//   byte_count      out  good bytes received while running, saturating
//   cycle_count     out  cycles spent running in this run
//   timeout         out  sticky, budget exhausted
//   done            out  sticky, run ended
//   dbg_ctrl_state  out  controller state (debug)
//   dbg_rx_state    out  receiver state (debug)
//
// Handshake: rx_valid and rx_frame_err are plain strobes with no ready;
// rx_data is stable from the rx_valid cycle until the next rx_valid, so a
// consumer may sample it on the strobe or any time later.
module cpu_run_monitor #(
    parameter int          RESET_CYCLES = 16,
    parameter int          CNT_W        = 32,
    parameter int unsigned MAX_CYCLES   = 3276800,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          DATA_BITS    = 8,
    parameter logic [DATA_BITS-1:0] END_CHAR = 8'h04
) (
    input  logic                 sysclk,
    input  logic                 cpu_reset,
    input  logic                 run_en,
    output logic                 core_resetn,
    input  logic                 uart_rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic [15:0]          byte_count,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 timeout,
    output logic                 done,
    output logic [1:0]           dbg_ctrl_state,
    output logic [2:0]           dbg_rx_state
);

`ifdef RUN_MON_END_CHAR_EN
    localparam bit END_CHAR_EN = 1'b1;
`else
    localparam bit END_CHAR_EN = 1'b0;
`endif

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        C_IDLE     = 2'd0,
        C_HOLD_RST = 2'd1,
        C_RUN      = 2'd2,
        C_DONE     = 2'd3
    } ctrl_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    // ---------------- receiver state ----------------
    logic [1:0]           sync_q, sync_d;
    logic                 rx_prev_q, rx_prev_d;
    rx_state_t            rx_state_q, rx_state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 rx_line;

    // ---------------- controller state ----------------
    ctrl_state_t          ctrl_state_q, ctrl_state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
    logic [15:0]          byte_count_q, byte_count_d;
    logic                 timeout_q, timeout_d;
    logic                 done_q, done_d;
    logic                 core_resetn_q, core_resetn_d;
    logic                 byte_hit;
    logic                 end_hit;

    // Synchronized line; sync_q[1] is the only copy used by the decoder.
    assign rx_line = sync_q[1];

    // ---------------- receiver next state ----------------
    always_comb begin
        sync_d         = {sync_q[0], uart_rx_in};
        rx_prev_d      = rx_line;
        rx_state_d     = rx_state_q;
        baud_cnt_d     = baud_cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_line) begin
                    rx_state_d = RX_START;
                    baud_cnt_d = '0;
                end
            end
            RX_START: begin
                // Sample mid start bit; a high line here was a glitch.
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d    = {rx_line, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (rx_line) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        rx_state_d     = RX_WAIT_HIGH;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                // Do not hunt for a start bit until the line has recovered.
                if (rx_line) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // ---------------- controller next state ----------------
    // Decisions use rx_valid_d so the byte count, the strobe and an
    // end-of-run caused by that byte all become visible on the same cycle.
    always_comb begin
        ctrl_state_d  = ctrl_state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        byte_count_d  = byte_count_q;
        timeout_d     = timeout_q;
        done_d        = done_q;

        byte_hit = rx_valid_d && (ctrl_state_q == C_RUN);
        end_hit  = END_CHAR_EN && byte_hit && (shift_q == END_CHAR);

        case (ctrl_state_q)
            C_IDLE: begin
                if (run_en) begin
                    ctrl_state_d  = C_HOLD_RST;
                    hold_cnt_d    = '0;
                    cycle_count_d = '0;
                    byte_count_d  = '0;
                    timeout_d     = 1'b0;
                    done_d        = 1'b0;
                end
            end
            C_HOLD_RST: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    ctrl_state_d = C_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            C_RUN: begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
                if (byte_hit && (byte_count_q != 16'hFFFF)) begin
                    byte_count_d = byte_count_q + 16'd1;
                end
                if (cycle_count_q == CYC_LAST) begin
                    timeout_d    = 1'b1;
                    done_d       = 1'b1;
                    ctrl_state_d = C_DONE;
                end
                if (end_hit) begin
                    done_d       = 1'b1;
                    ctrl_state_d = C_DONE;
                end
            end
            C_DONE: begin
                if (!run_en) begin
                    ctrl_state_d = C_IDLE;
                end
            end
            default: begin
                ctrl_state_d = C_IDLE;
            end
        endcase

        core_resetn_d = (ctrl_state_d == C_RUN);
    end

    // ---------------- registers ----------------
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            // Synchronizer resets to the idle level so release is not
            // mistaken for a start bit.
            sync_q         <= 2'b11;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= RX_IDLE;
            baud_cnt_q     <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            ctrl_state_q   <= C_IDLE;
            hold_cnt_q     <= '0;
            cycle_count_q  <= '0;
            byte_count_q   <= '0;
            timeout_q      <= 1'b0;
            done_q         <= 1'b0;
            core_resetn_q  <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            rx_prev_q      <= rx_prev_d;
            rx_state_q     <= rx_state_d;
            baud_cnt_q     <= baud_cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            ctrl_state_q   <= ctrl_state_d;
            hold_cnt_q     <= hold_cnt_d;
            cycle_count_q  <= cycle_count_d;
            byte_count_q   <= byte_count_d;
            timeout_q      <= timeout_d;
            done_q         <= done_d;
            core_resetn_q  <= core_resetn_d;
        end
    end

    assign core_resetn    = core_resetn_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign rx_frame_err   = rx_frame_err_q;
    assign byte_count     = byte_count_q;
    assign cycle_count    = cycle_count_q;
    assign timeout        = timeout_q;
    assign done           = done_q;
    assign dbg_ctrl_state = ctrl_state_q;
    assign dbg_rx_state   = rx_state_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: reset/start, cycle budget, byte reception
// table, framing and glitch cases, mid-byte reset, END_CHAR handling and
// randomized frames against a byte-level reference model.
module tb_cpu_run_monitor;

    localparam int CPB       = 16;
    localparam int RST_CYC   = 4;
    localparam int MAX_CYC   = 1000;
    localparam int CNT_W     = 32;

    // ---------------- clock / reset ----------------
    logic        sysclk = 1'b0;
    logic        cpu_reset;
    logic        run_en;
    logic        uart_rx_in;
    logic        core_resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic [15:0] byte_count;
    logic [CNT_W-1:0] cycle_count;
    logic        timeout;
    logic        done;
    logic [1:0]  dbg_ctrl_state;
    logic [2:0]  dbg_rx_state;

    always #5 sysclk = ~sysclk;

    cpu_run_monitor #(
        .RESET_CYCLES(RST_CYC),
        .CNT_W(CNT_W),
        .MAX_CYCLES(MAX_CYC),
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .END_CHAR(8'h04)
    ) dut (
        .sysclk(sysclk),
        .cpu_reset(cpu_reset),
        .run_en(run_en),
        .core_resetn(core_resetn),
        .uart_rx_in(uart_rx_in),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err),
        .byte_count(byte_count),
        .cycle_count(cycle_count),
        .timeout(timeout),
        .done(done),
        .dbg_ctrl_state(dbg_ctrl_state),
        .dbg_rx_state(dbg_rx_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    int ferr_n   = 0;
    int valid_n  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every rx_valid strobe must match the oldest byte sent with a good stop bit.
    always @(negedge sysclk) begin
        if (rx_valid) begin
            valid_n++;
            check("valid_and_ferr_exclusive", {63'd0, rx_frame_err}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_rx_valid", {56'd0, rx_data}, 64'hDEAD);
            end else begin
                check("rx_valid_data", {56'd0, rx_data}, {56'd0, exp_q.pop_front()});
            end
        end
        if (rx_frame_err) ferr_n++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    // All driving and sampling happens at the falling edge.
    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        uart_rx_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            repeat (CPB) tick();
        end
        uart_rx_in = stop_ok;
        repeat (CPB) tick();
        uart_rx_in = 1'b1;
        if (!stop_ok) repeat (4) tick();
    endtask

    task automatic send_glitch();
        uart_rx_in = 1'b0;
        repeat (4) tick();
        uart_rx_in = 1'b1;
        repeat (20) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_resetn"}, {63'd0, core_resetn}, 64'd0);
        check({tag, "_rx_data"}, {56'd0, rx_data}, 64'd0);
        check({tag, "_rx_valid"}, {63'd0, rx_valid}, 64'd0);
        check({tag, "_rx_frame_err"}, {63'd0, rx_frame_err}, 64'd0);
        check({tag, "_byte_count"}, {48'd0, byte_count}, 64'd0);
        check({tag, "_cycle_count"}, {32'd0, cycle_count}, 64'd0);
        check({tag, "_timeout"}, {63'd0, timeout}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
    endtask

    task automatic wait_run_start(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (core_resetn) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_run_start_bound"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_bound"}, {63'd0, ok}, 64'd1);
    endtask

    // Start a clean run through cpu_reset; run_en stays high.
    task automatic fresh_run(input string tag);
        cpu_reset  = 1'b1;
        run_en     = 1'b1;
        uart_rx_in = 1'b1;
        tick();
        tick();
        cpu_reset = 1'b0;
        wait_run_start(tag);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [7:0]  data;
        bit          stop_ok;
        bit          glitch;
        logic [7:0]  exp_rx_data;
        logic [15:0] exp_bytes;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[5];

    // ---------------- main sequence ----------------
    initial begin
        int low_n;
        int high_n;
        int ferr_base;
        int m_bytes;
        int m_ferr;
        logic [7:0] m_last;
        logic [7:0] pat;
        logic [7:0] b;
        bit ok;

        vecs[0] = '{8'h41, 1'b1, 1'b0, 8'h41, 16'd1, 0};
        vecs[1] = '{8'h0A, 1'b1, 1'b0, 8'h0A, 16'd2, 0};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 8'h55, 16'd3, 0};
        vecs[3] = '{8'hC3, 1'b0, 1'b0, 8'h55, 16'd3, 1};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h55, 16'd3, 1};

        // Reset state.
        cpu_reset  = 1'b1;
        run_en     = 1'b0;
        uart_rx_in = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");

        // Start: hold low for RST_CYC cycles after the run is accepted.
        cpu_reset = 1'b0;
        run_en    = 1'b1;
        low_n = 0;
        ok    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (core_resetn) begin
                ok = 1'b1;
                break;
            end
            low_n++;
        end
        check("start_seen", {63'd0, ok}, 64'd1);
        check("hold_low_cycles", low_n, RST_CYC);
        check("cycle_count_first", {32'd0, cycle_count}, 64'd0);
        high_n = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            high_n++;
            check("cycle_count_step", {32'd0, cycle_count}, k);
        end

        // Budget: idle line, run ends after exactly MAX_CYC running cycles.
        ok = 1'b0;
        for (int i = 0; i < MAX_CYC + 50; i++) begin
            tick();
            if (!core_resetn) begin
                ok = 1'b1;
                break;
            end
            high_n++;
        end
        check("budget_end_seen", {63'd0, ok}, 64'd1);
        check("budget_run_cycles", high_n, MAX_CYC);
        check("budget_timeout", {63'd0, timeout}, 64'd1);
        check("budget_done", {63'd0, done}, 64'd1);
        check("budget_cycle_count", {32'd0, cycle_count}, MAX_CYC);
        repeat (20) tick();
        check("done_cycle_frozen", {32'd0, cycle_count}, MAX_CYC);
        check("done_core_resetn", {63'd0, core_resetn}, 64'd0);
        run_en = 1'b0;
        tick();
        tick();
        check("idle_keeps_done", {63'd0, done}, 64'd1);
        check("idle_keeps_timeout", {63'd0, timeout}, 64'd1);
        check("idle_keeps_cycles", {32'd0, cycle_count}, MAX_CYC);
        run_en = 1'b1;
        tick();
        check("restart_clears_done", {63'd0, done}, 64'd0);
        check("restart_clears_timeout", {63'd0, timeout}, 64'd0);
        check("restart_clears_cycles", {32'd0, cycle_count}, 64'd0);
        wait_run_start("table");

        // Byte table, all inside one run.
        ferr_base = ferr_n;
        foreach (vecs[i]) begin
            if (vecs[i].glitch) begin
                send_glitch();
            end else begin
                if (vecs[i].stop_ok) exp_q.push_back(vecs[i].data);
                send_frame(vecs[i].data, vecs[i].stop_ok);
            end
            tick();
            tick();
            check("table_rx_data", {56'd0, rx_data}, {56'd0, vecs[i].exp_rx_data});
            check("table_byte_count", {48'd0, byte_count}, {48'd0, vecs[i].exp_bytes});
            check("table_frame_errs", ferr_n - ferr_base, vecs[i].exp_ferr);
        end
        wait_done("table", MAX_CYC);
        check("table_final_bytes", {48'd0, byte_count}, 64'd3);
        check("table_final_timeout", {63'd0, timeout}, 64'd1);

        // Reset in the middle of bit 3 of a byte.
        pat = 8'hA5;
        uart_rx_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 3; i++) begin
            uart_rx_in = pat[i];
            repeat (CPB) tick();
        end
        uart_rx_in = pat[3];
        repeat (CPB / 2) tick();
        cpu_reset  = 1'b1;
        uart_rx_in = 1'b1;
        tick();
        check_all_zero("midrst");
        tick();
        cpu_reset = 1'b0;
        wait_run_start("midrst");
        repeat (10) tick();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick();
        tick();
        check("midrst_rx_data", {56'd0, rx_data}, 64'h3C);
        check("midrst_byte_count", {48'd0, byte_count}, 64'd1);

        // END_CHAR around cycle 300.
        fresh_run("endchar");
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (cycle_count >= 300) begin
                ok = 1'b1;
                break;
            end
        end
        check("endchar_reach_300", {63'd0, ok}, 64'd1);
        exp_q.push_back(8'h04);
        send_frame(8'h04, 1'b1);
        wait_done("endchar", MAX_CYC);
        check("endchar_byte_count", {48'd0, byte_count}, 64'd1);
`ifdef RUN_MON_END_CHAR_EN
        check("endchar_timeout", {63'd0, timeout}, 64'd0);
        check("endchar_early", {63'd0, (cycle_count < MAX_CYC)}, 64'd1);
`else
        check("endchar_timeout", {63'd0, timeout}, 64'd1);
        check("endchar_cycle_count", {32'd0, cycle_count}, MAX_CYC);
`endif

        // Randomized frames against a byte-level model.
        for (int r = 0; r < 3; r++) begin
            fresh_run("rand");
            m_bytes   = 0;
            m_ferr    = 0;
            m_last    = 8'h00;
            ferr_base = ferr_n;
            for (int f = 0; f < 5; f++) begin
                int kind;
                uart_rx_in = 1'b1;
                repeat ($urandom_range(0, 10)) tick();
                kind = $urandom_range(0, 9);
                b    = 8'($urandom_range(0, 255));
                if (b == 8'h04) b = 8'h05;
                if (kind == 0) begin
                    send_glitch();
                end else if (kind == 1) begin
                    send_frame(b, 1'b0);
                    m_ferr++;
                end else begin
                    exp_q.push_back(b);
                    send_frame(b, 1'b1);
                    m_bytes++;
                    m_last = b;
                end
                tick();
                tick();
                check("rand_rx_data", {56'd0, rx_data}, {56'd0, m_last});
                check("rand_byte_count", {48'd0, byte_count}, m_bytes);
                check("rand_frame_errs", ferr_n - ferr_base, m_ferr);
            end
            wait_done("rand", MAX_CYC + 50);
            check("rand_timeout", {63'd0, timeout}, 64'd1);
            check("rand_cycle_count", {32'd0, cycle_count}, MAX_CYC);
            check("rand_final_bytes", {48'd0, byte_count}, m_bytes);
        end

        tick();
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
